uart_tx: RTL and testbench

- Byte-oriented UART transmitter: 8N1 framing, LSB first, with a small input FIFO so the host can queue bytes while a frame is on the line.
- Serializes each queued byte onto `TX_data` at a fixed baud set in clock cycles per bit.
- Counterpart of the team's `UART_RX`; default timing matches it (20 clocks per bit, 400 ns bit at a 50 MHz clock).

---
 rtl/uart_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-oriented 8N1 UART transmitter with a small input FIFO
//
// Purpose: queues bytes written by the host and serializes each one LSB first
// as start(0), 8 data bits, [even parity], stop(1) at CLKS_PER_BIT clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity bit per frame).
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - asynchronous active-high reset
//   TX_byte        - byte to queue, sampled when send_strobe is high
//   send_strobe    - write request, one byte per high cycle
//   TX_data        - serial line, idles high (registered)
//   transmit_state - high while a frame is on the line (registered)
//   fifo_full      - FIFO holds FIFO_DEPTH entries (registered)
//   overflow       - one-cycle pulse after a rejected write (registered)

module uart_tx #(
   parameter int CLKS_PER_BIT = 20,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] TX_byte,
   input  logic       send_strobe,
   output logic       TX_data,
   output logic       transmit_state,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_PARITY = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
   } state_t;
`endif

   // ---------------- input FIFO ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_full_q, overflow_q;
   logic          wr_en, pop;
   logic [7:0]    head;

   // Acceptance looks at occupancy before any same-cycle pop, so a full FIFO
   // rejects a write even on the cycle its head is being popped.
   assign wr_en = send_strobe && (count_q < DEPTH_C);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= TX_byte;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fifo_full_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q     <= count_d;
         fifo_full_q <= (count_d == DEPTH_C);
         overflow_q  <= send_strobe && !wr_en;
      end
   end

   // ---------------- transmit FSM ----------------
   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q;
   logic          baud_last;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
`ifdef UART_TX_PARITY_EN
               parity_d = ^head;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
         end
      endcase

      // Line level is derived from the next state so the registered output
      // changes on the same edge as the state it belongs to.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign TX_data        = tx_q;
   assign transmit_state = busy_q;
   assign fifo_full      = fifo_full_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model

module tb_uart_tx;

   localparam int CPB   = 20;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] TX_byte = 8'd0;
   logic       send_strobe = 1'b0;
   logic       TX_data, transmit_state, fifo_full, overflow;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .TX_byte        (TX_byte),
      .send_strobe    (send_strobe),
      .TX_data        (TX_data),
      .transmit_state (transmit_state),
      .fifo_full      (fifo_full),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a queue of accepted bytes plus the position inside the
   // frame currently on the line (rem = cycles left, pos = cycles elapsed).
   logic [7:0] m_q[$];
   logic [7:0] m_cur = 8'd0;
   int         m_rem = 0;
   int         m_pos = 0;
   logic       m_ovf = 1'b0;

   int hi_cnt = 0, ovf_cnt = 0, run = 0, max_run = 0;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic logic m_tx();
      if (m_rem > 0) return frame_bit(m_cur, m_pos / CPB);
      return 1'b1;
   endfunction

   task automatic model_edge(input logic s, input logic [7:0] b);
      bit pop, acc;
      pop   = (m_q.size() > 0) && (m_rem <= 1);
      acc   = s && (m_q.size() < DEPTH);
      m_ovf = s && !acc;
      if (pop) begin
         m_cur = m_q.pop_front();
         m_rem = FRAME;
         m_pos = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         m_pos++;
      end
      if (acc) m_q.push_back(b);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rem = 0;
      m_pos = 0;
      m_ovf = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("tx_data", {31'd0, TX_data}, {31'd0, m_tx()});
      check("transmit_state", {31'd0, transmit_state}, {31'd0, (m_rem > 0)});
      check("fifo_full", {31'd0, fifo_full}, {31'd0, (m_q.size() == DEPTH)});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic tick(input logic s, input logic [7:0] b);
      send_strobe = s;
      TX_byte     = b;
      @(posedge clk);
      model_edge(s, b);
      #1;
      send_strobe = 1'b0;
      check_outputs();
      if (transmit_state) begin
         hi_cnt++;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (overflow) ovf_cnt++;
   endtask

   task automatic clear_stats();
      hi_cnt = 0; ovf_cnt = 0; run = 0; max_run = 0;
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      repeat (5) tick(1'b0, 8'd0);

      // Single byte 0x55
      clear_stats();
      tick(1'b1, 8'h55);
      repeat (FRAME + 20) tick(1'b0, 8'd0);
      check("single_hi_cycles", hi_cnt, FRAME);

      // Back-to-back 0xAA, 0x0F
      clear_stats();
      tick(1'b1, 8'hAA);
      tick(1'b1, 8'h0F);
      repeat (2 * FRAME + 20) tick(1'b0, 8'd0);
      check("b2b_hi_cycles", hi_cnt, 2 * FRAME);
      check("b2b_continuous", max_run, 2 * FRAME);

      // Overflow: six strobes 0x01..0x06
      clear_stats();
      for (int i = 1; i <= 6; i++) begin
         tick(1'b1, 8'(i));
         if (i == 5) check("full_after_5", {31'd0, fifo_full}, 32'd1);
      end
      repeat (5 * FRAME + 20) tick(1'b0, 8'd0);
      check("ovf_pulses", ovf_cnt, 1);
      check("ovf_frames_cycles", hi_cnt, 5 * FRAME);
      check("ovf_continuous", max_run, 5 * FRAME);

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         tick($urandom_range(0, 9) == 0, 8'($urandom));
      end
      repeat ((DEPTH + 1) * FRAME + 20) tick(1'b0, 8'd0);

      // Reset during data bit 3 of 0x33 with two bytes queued
      tick(1'b1, 8'h33);
      tick(1'b1, 8'h44);
      tick(1'b1, 8'h55);
      check("queued_two", m_q.size(), 2);
      for (int i = 0; i < 400 && !(m_rem > 0 && m_pos == 4 * CPB + 10); i++) begin
         tick(1'b0, 8'd0);
      end
      check("reached_bit3", m_pos, 4 * CPB + 10);
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("rst_tx_data", {31'd0, TX_data}, 32'd1);
      check("rst_transmit_state", {31'd0, transmit_state}, 32'd0);
      check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      clear_stats();
      repeat (FRAME + 50) tick(1'b0, 8'd0);
      check("post_rst_no_frame", hi_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
